img_sram_stream_tx: RTL

Parametrised successor to the IO transmit controller. It reads an nrows x ncols image from a single-port image SRAM with a configurable read latency and streams the pixels out over a valid/ready interface with full backpressure. Readout is row-major or column-major. It sits between the image SRAM and the output pad/serializer logic, and the SRAM mux selects it during the transmit phase.

---
 rtl/img_sram_stream_tx_if.sv | 14 +
 rtl/img_sram_stream_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/img_sram_stream_tx_if.sv
// Pixel stream carried from the SRAM transmit controller to the pad/serializer
// logic: valid/ready handshake with data plus end-of-line and end-of-image flags.
interface img_sram_stream_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;
    logic              eol;
    logic              last;

    modport master (output valid, output data, output eol, output last, input ready);
    modport slave  (input valid, input data, input eol, input last, output ready);
endinterface

// File: rtl/img_sram_stream_tx.sv
// Image SRAM transmit controller: walks an nrows x ncols image in row- or
// column-major order, issues one SRAM read per cycle while output credit lasts,
// and streams the returned pixels through a small FIFO with full backpressure.
module img_sram_stream_tx #(
    parameter int DATA_W     = 8,
    parameter int DIM_W      = 8,
    parameter int ADDR_W     = 14,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              col_major,
    input  logic [DIM_W-1:0]  nrows,
    input  logic [DIM_W-1:0]  ncols,
    output logic              busy,
    output logic              done,
    output logic              sram_en,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_rdata,
    img_sram_stream_if.master m
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + RD_LAT + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_FIN   = 2'd3;

    generate
        if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
            $error("img_sram_stream_tx: RD_LAT must be in 1..4");
        end
        if (FIFO_DEPTH < RD_LAT + 2) begin : g_bad_depth
            $error("img_sram_stream_tx: FIFO_DEPTH must be >= RD_LAT+2");
        end
    endgenerate

    logic [1:0]        state;
    logic              cm_q;
    logic [DIM_W-1:0]  nrows_q, ncols_q;
    logic [DIM_W-1:0]  r_q, c_q;

    // Read-return pipeline: bit N is stage N after issue; the top bit lines up with sram_rdata.
    logic [RD_LAT-1:0] vld_p, eol_p, last_p;

    logic [DATA_W+1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  fifo_cnt, inflight;
    logic [DATA_W+1:0] head;

    logic r_end, c_end, issue_eol, issue_last, credit, issue, push, pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign r_end      = (r_q == nrows_q - DIM_W'(1));
    assign c_end      = (c_q == ncols_q - DIM_W'(1));
    assign issue_eol  = cm_q ? r_end : c_end;
    assign issue_last = r_end && c_end;

    // Reads already issued but not yet landed in the FIFO still consume credit.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CNT_W'(vld_p[i]);
        end
    end

    // A pop this cycle deliberately does not free credit, keeping the credit path off m_ready.
    assign credit = (fifo_cnt + inflight) < CNT_W'(FIFO_DEPTH);
    assign issue  = (state == S_ISSUE) && credit;
    assign push   = vld_p[RD_LAT-1];
    assign pop    = m.valid && m.ready;

    assign sram_en   = issue;
    assign sram_addr = issue ? (ADDR_W'(r_q) * ADDR_W'(ncols_q) + ADDR_W'(c_q)) : '0;
    assign busy      = (state == S_ISSUE) || (state == S_DRAIN);
    assign done      = (state == S_FIN);

    assign head    = fifo_mem[rd_ptr];
    assign m.valid = (fifo_cnt != '0);
    assign m.data  = m.valid ? head[DATA_W+1:2] : '0;
    assign m.eol   = m.valid && head[1];
    assign m.last  = m.valid && head[0];

    // Transfer FSM with configuration capture and row/column address counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            cm_q    <= 1'b0;
            nrows_q <= '0;
            ncols_q <= '0;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cm_q    <= col_major;
                        nrows_q <= nrows;
                        ncols_q <= ncols;
                        r_q     <= '0;
                        c_q     <= '0;
                        state   <= (nrows == '0 || ncols == '0) ? S_FIN : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (issue) begin
                        if (issue_last) state <= S_DRAIN;
                        if (!cm_q) begin
                            if (c_end) begin
                                c_q <= '0;
                                r_q <= r_q + 1'b1;
                            end else begin
                                c_q <= c_q + 1'b1;
                            end
                        end else begin
                            if (r_end) begin
                                r_q <= '0;
                                c_q <= c_q + 1'b1;
                            end else begin
                                r_q <= r_q + 1'b1;
                            end
                        end
                    end
                end
                // The final beat leaving the FIFO implies nothing is left in flight or queued.
                S_DRAIN: if (pop && m.last) state <= S_FIN;
                S_FIN:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Valid shift for outstanding reads; clearing it on rst drops any data still returning.
    always_ff @(posedge clk) begin
        if (rst) vld_p <= '0;
        else     vld_p <= (vld_p << 1) | RD_LAT'(issue);
    end

    // Sideband flags ride alongside the valid bits; qualified by vld_p so no reset needed.
    always_ff @(posedge clk) begin
        eol_p  <= (eol_p << 1)  | RD_LAT'(issue_eol);
        last_p <= (last_p << 1) | RD_LAT'(issue_last);
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave the count unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage: pixel with its eol/last flags.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= {sram_rdata, eol_p[RD_LAT-1], last_p[RD_LAT-1]};
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && fifo_cnt == CNT_W'(FIFO_DEPTH)));
endmodule
